nw_cell_scheduler: RTL and testbench
====================================

Name: nw_cell_scheduler

Overview:
- Control and compute stage directly downstream of the score manager.
- Walks the matrix cells (i,j) in row-major order: i=1..N, j=1..N.
- For each cell it requests the diag/left/up triplet from the score manager, then computes the cell score and traceback direction.
- It writes the score back through the manager's insert path (max, en_ins, we) and emits the direction to the traceback store.

Parameters:
- N, 128, sequence length; matrix is (N+1)x(N+1).
- BitAddr, $clog2(N+1), index width minus one; i and j are [BitAddr:0].
- MATCH, 1, signed score added to diag on equal characters.
- MISMATCH, -1, signed score added to diag on unequal characters.
- GAP, -2, signed score added to up and to left.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start of a fill pass; sampled only in IDLE.
- a_char  in  2  nucleotide of sequence A at index i; valid whenever i is stable.
- b_char  in  2  nucleotide of sequence B at index j; valid whenever j is stable.
- signal  in  1  from the score manager's 3-counter; high means diag/left/up are valid this cycle.
- diag  in  9  signed score of cell (i-1,j-1).
- left  in  9  signed score of cell (i,j-1).
- up  in  9  signed score of cell (i-1,j).
- i  out  BitAddr+1  current row index.
- j  out  BitAddr+1  current column index.
- en_read  out  1  read enable to the score manager.
- en_counter_3  out  1  triplet counter enable to the score manager.
- en_ins  out  1  insert enable to the score manager.
- we  out  1  RAM write enable to the score manager.
- max  out  9  signed computed cell score.
- dir  out  2  traceback direction: 00 diag, 01 up, 10 left; 11 is never produced.
- dir_we  out  1  one-cycle strobe; dir is valid for cell (i,j).
- busy  out  1  high from leaving IDLE until DONE is exited.
- done  out  1  one-cycle pulse when the last cell is written.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; i=1, j=1.
  - max=0, dir=00; all enables, dir_we, busy and done low.
  - Reset mid-pass aborts the pass immediately; no partial write is completed.
- States and transitions:
  - IDLE: start=1 -> READ, busy=1; otherwise stay.
  - READ: en_read=en_counter_3=1 every cycle. When signal=1, capture diag/left/up and a_char/b_char into registers, then -> CALC. While signal=0, stay; there is no timeout.
  - CALC (1 cycle): no outputs enabled.
    - s_d = diag_r + (a_r==b_r ? MATCH : MISMATCH); s_u = up_r + GAP; s_l = left_r + GAP.
    - All three sums are formed in 10-bit signed arithmetic, sign-extended.
    - Result = largest sum; tie priority diag > up > left.
    - max <= result[8:0]; dir <= code of the winner.
  - WRITE (1 cycle): en_ins=1, we=1, dir_we=1. max and dir are held stable. i and j still address the current cell. -> NEXT.
  - NEXT (1 cycle):
    - If j==N and i==N: -> DONE.
    - Else if j==N: j <= 1, i <= i+1, -> READ.
    - Else: j <= j+1, -> READ.
  - DONE (1 cycle): done=1; then -> IDLE with busy=0, i=1, j=1. max/dir keep their last values.
- Timing:
  - A start pulse shorter than one cycle outside IDLE is ignored; start held high in DONE does not restart until IDLE is reached.
  - Per-cell latency = (READ cycles, including the signal cycle) + 3.
- Width rule: with GAP=-2 and N=128, every legal score lies in [-256,+128] and fits 9-bit signed. The 10-bit intermediate only guards the s_u/s_l = -258 case. That case always loses to diag unless all three sums are equal-low, which cannot occur with legal boundary values.
- Exactly one en_ins/we/dir_we pulse per cell: N*N pulses per pass, in row-major order.

Test Plan:
- Reset: assert rst=0 mid-READ with i=3, j=5 -> next edge shows IDLE outputs, i=j=1, all enables 0, busy=0; no write pulse occurs.
- Single cell match: diag=5, up=2, left=3, a_char=b_char=2'b01, signal on the 2nd READ cycle -> max=6, dir=00; WRITE pulse 2 cycles after the signal cycle.
- Gap win and ties:
  - Mismatch with diag=0, up=4, left=4 -> max=2, dir=01 (up beats left).
  - diag=1 mismatch, up=2 -> max=0, dir=00 (diag wins the tie).
- Negative range: diag=-256, up=-255, left=-250, mismatch -> max=-252, dir=10; max is 9'h104.
- Full pass with N=4 and signal asserted on the 3rd cycle of each READ -> 16 write pulses with (i,j) = (1,1)..(1,4),(2,1)..(4,4); done pulses once; busy falls the cycle after done.
- start held high through DONE -> exactly one pass, then a second pass starts from IDLE with i=j=1.

Source files
------------

// File: rtl/nw_cell_scheduler_if.sv
// ---------------------------------------------------------------------------
// nw_cell_scheduler_if
// Bundles the signals between the Needleman-Wunsch cell scheduler, the score
// manager and the traceback store.
//   start            fill-pass request from the controller
//   a_char / b_char  nucleotides of sequence A at row i and sequence B at column j
//   signal           score manager: diag/left/up are valid this cycle
//   diag/left/up     signed 9-bit neighbour scores of the current cell
//   i / j            current cell address
//   en_read, en_counter_3  read request to the score manager
//   en_ins, we, max  insert path carrying the computed cell score
//   dir, dir_we      traceback direction and its one-cycle strobe
//   busy, done       pass status
// The slave modport is the scheduler; the master modport is its environment.
// ---------------------------------------------------------------------------
interface nw_cell_scheduler_if #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
);
  logic                start;
  logic [1:0]          a_char;
  logic [1:0]          b_char;
  logic                signal;
  logic signed [8:0]   diag;
  logic signed [8:0]   left;
  logic signed [8:0]   up;
  logic [BitAddr:0]    i;
  logic [BitAddr:0]    j;
  logic                en_read;
  logic                en_counter_3;
  logic                en_ins;
  logic                we;
  logic signed [8:0]   max;
  logic [1:0]          dir;
  logic                dir_we;
  logic                busy;
  logic                done;

  modport slave (
    input  start, a_char, b_char, signal, diag, left, up,
    output i, j, en_read, en_counter_3, en_ins, we, max, dir, dir_we, busy, done
  );

  modport master (
    output start, a_char, b_char, signal, diag, left, up,
    input  i, j, en_read, en_counter_3, en_ins, we, max, dir, dir_we, busy, done
  );
endinterface

// File: rtl/nw_cell_scheduler.sv
// ---------------------------------------------------------------------------
// nw_cell_scheduler
// Walks the (N+1)x(N+1) alignment matrix in row-major order over cells
// i=1..N, j=1..N. For every cell it requests the diag/left/up triplet from the
// score manager, computes the cell score and traceback direction, writes the
// score back through the insert path and strobes the direction out.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous, active-low reset
//   bus  scheduler side (slave modport) of nw_cell_scheduler_if
// Per-cell sequence: READ (until signal) -> CALC -> WRITE -> NEXT.
// ---------------------------------------------------------------------------
module nw_cell_scheduler #(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N + 1),
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
) (
  input  logic              clk,
  input  logic              rst,
  nw_cell_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WRITE,
    NEXT,
    DONE
  } state_t;

  localparam logic [BitAddr:0]  LAST      = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0]  FIRST     = (BitAddr + 1)'(1);
  localparam logic signed [9:0] MATCH_W   = 10'(MATCH);
  localparam logic signed [9:0] MISMATCH_W = 10'(MISMATCH);
  localparam logic signed [9:0] GAP_W     = 10'(GAP);

  state_t            state_q;
  logic [BitAddr:0]  i_q, j_q;
  logic signed [8:0] diag_q, left_q, up_q;
  logic [1:0]        a_q, b_q;
  logic signed [8:0] max_q;
  logic [1:0]        dir_q;
  logic              en_read_q;
  logic              en_ins_q;
  logic              busy_q;
  logic              done_q;

  // Cell score datapath. Sums are 10 bits wide so that up/left + GAP at the
  // bottom of the range (-258) still compares correctly against diag.
  logic signed [9:0] s_d, s_u, s_l;
  logic signed [8:0] max_d;
  logic [1:0]        dir_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it leaves a value unassigned and infers a latch.
  always_comb begin
    s_d   = 10'(diag_q) + ((a_q == b_q) ? MATCH_W : MISMATCH_W);
    s_u   = 10'(up_q) + GAP_W;
    s_l   = 10'(left_q) + GAP_W;
    max_d = s_d[8:0];
    dir_d = 2'b00;
    // Ties resolve diag > up > left.
    if (s_d >= s_u && s_d >= s_l) begin
      max_d = s_d[8:0];
      dir_d = 2'b00;
    end else if (s_u >= s_l) begin
      max_d = s_u[8:0];
      dir_d = 2'b01;
    end else begin
      max_d = s_l[8:0];
      dir_d = 2'b10;
    end
  end

  // Single FSM process; every output is a register updated on the transition
  // into the state that owns it, so outputs are glitch-free and aligned with
  // the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_q       <= FIRST;
      j_q       <= FIRST;
      diag_q    <= '0;
      left_q    <= '0;
      up_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      max_q     <= '0;
      dir_q     <= 2'b00;
      en_read_q <= 1'b0;
      en_ins_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            en_read_q <= 1'b1;
          end
        end
        READ: begin
          // No timeout: the score manager always delivers eventually.
          if (bus.signal) begin
            diag_q    <= bus.diag;
            left_q    <= bus.left;
            up_q      <= bus.up;
            a_q       <= bus.a_char;
            b_q       <= bus.b_char;
            en_read_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          max_q    <= max_d;
          dir_q    <= dir_d;
          en_ins_q <= 1'b1;
          state_q  <= WRITE;
        end
        WRITE: begin
          en_ins_q <= 1'b0;
          state_q  <= NEXT;
        end
        NEXT: begin
          if (j_q == LAST && i_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            if (j_q == LAST) begin
              j_q <= FIRST;
              i_q <= i_q + FIRST;
            end else begin
              j_q <= j_q + FIRST;
            end
            en_read_q <= 1'b1;
            state_q   <= READ;
          end
        end
        DONE: begin
          // max/dir deliberately keep the last cell's values.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          i_q     <= FIRST;
          j_q     <= FIRST;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i            = i_q;
  assign bus.j            = j_q;
  assign bus.en_read      = en_read_q;
  assign bus.en_counter_3 = en_read_q;
  assign bus.en_ins       = en_ins_q;
  assign bus.we           = en_ins_q;
  assign bus.dir_we       = en_ins_q;
  assign bus.max          = max_q;
  assign bus.dir          = dir_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_nw_cell_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nw_cell_scheduler
// Directed bench for nw_cell_scheduler with N=4. The bench plays the score
// manager: for each cell it presents a hand-computed diag/up/left/char vector,
// raises signal on a chosen READ cycle and pushes the expected write into a
// scoreboard. An independent monitor pops and compares on every dir_we strobe.
// ---------------------------------------------------------------------------
module tb_nw_cell_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nw_cell_scheduler_if #(.N(N)) bus ();

  nw_cell_scheduler #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         diag;
    int         up;
    int         left;
    logic [1:0] a;
    logic [1:0] b;
    int         emax;
    logic [1:0] edir;
  } vec_t;

  typedef struct {
    int i;
    int j;
    int max;
    int dir;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int write_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe against the scoreboard.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.dir_we) begin
      write_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_i", int'(bus.i), mon_e.i);
        check("wr_j", int'(bus.j), mon_e.j);
        check("wr_max", int'(bus.max), mon_e.max);
        check("wr_dir", int'(bus.dir), mon_e.dir);
        check("wr_en_ins", int'(bus.en_ins), 1);
        check("wr_we", int'(bus.we), 1);
      end
    end
  end

  // Serve one cell. Called at a negedge; returns at the negedge after NEXT.
  task automatic do_cell(input int idx, input int delay, input int ci, input int cj);
    int budget;
    budget = 0;
    while (!bus.en_read && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.en_read) begin
      check("wait_en_read", 0, 1);
      return;
    end
    check("en_counter_3", int'(bus.en_counter_3), 1);
    bus.diag   = 9'(vecs[idx].diag);
    bus.up     = 9'(vecs[idx].up);
    bus.left   = 9'(vecs[idx].left);
    bus.a_char = vecs[idx].a;
    bus.b_char = vecs[idx].b;
    for (int k = 1; k < delay; k++) begin
      bus.signal = 1'b0;
      @(negedge clk);
    end
    sb_q.push_back('{ci, cj, vecs[idx].emax, int'(vecs[idx].edir)});
    bus.signal = 1'b1;
    @(negedge clk);
    bus.signal = 1'b0;
    check("calc_no_write", int'(bus.dir_we), 0);
    check("calc_no_read", int'(bus.en_read), 0);
    @(negedge clk);
    check("write_latency", int'(bus.dir_we), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            diag  up   left  a     b     max   dir
    vecs[0]  = '{5,    2,   3,    2'd1, 2'd1, 6,    2'b00};
    vecs[1]  = '{0,    4,   4,    2'd0, 2'd1, 2,    2'b01};
    vecs[2]  = '{1,    2,   0,    2'd2, 2'd3, 0,    2'b00};
    vecs[3]  = '{-256, -255, -250, 2'd0, 2'd3, -252, 2'b10};
    vecs[4]  = '{0,    0,   0,    2'd2, 2'd2, 1,    2'b00};
    vecs[5]  = '{3,    10,  4,    2'd1, 2'd2, 8,    2'b01};
    vecs[6]  = '{-5,   -5,  0,    2'd3, 2'd3, -2,   2'b10};
    vecs[7]  = '{127,  0,   0,    2'd0, 2'd0, 128,  2'b00};
    vecs[8]  = '{-10,  -7,  -7,   2'd1, 2'd1, -9,   2'b00};
    vecs[9]  = '{-10,  -6,  -6,   2'd1, 2'd0, -8,   2'b01};
    vecs[10] = '{20,   15,  30,   2'd2, 2'd2, 28,   2'b10};
    vecs[11] = '{-100, -97, -99,  2'd3, 2'd0, -99,  2'b01};
    vecs[12] = '{50,   52,  53,   2'd0, 2'd1, 51,   2'b10};
    vecs[13] = '{-1,   1,   1,    2'd2, 2'd2, 0,    2'b00};
    vecs[14] = '{64,   66,  66,   2'd3, 2'd1, 64,   2'b01};
    vecs[15] = '{-254, -256, -256, 2'd0, 2'd0, -253, 2'b00};

    bus.start  = 1'b0;
    bus.signal = 1'b0;
    bus.a_char = '0;
    bus.b_char = '0;
    bus.diag   = '0;
    bus.up     = '0;
    bus.left   = '0;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check("rst_i", int'(bus.i), 1);
    check("rst_j", int'(bus.j), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_en_read", int'(bus.en_read), 0);
    check("rst_done", int'(bus.done), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // Pass aborted by reset during READ of cell (1,3).
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", int'(bus.busy), 1);
    do_cell(0, 2, 1, 1);
    do_cell(1, 1, 1, 2);
    check("abort_in_read", int'(bus.en_read), 1);
    check("abort_i", int'(bus.i), 1);
    check("abort_j", int'(bus.j), 3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_i_rst", int'(bus.i), 1);
    check("abort_j_rst", int'(bus.j), 1);
    check("abort_en_read", int'(bus.en_read), 0);
    check("abort_en_cnt3", int'(bus.en_counter_3), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_max", int'(bus.max), 0);
    check("abort_dir", int'(bus.dir), 0);
    check("abort_dir_we", int'(bus.dir_we), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full pass, start held high throughout, signal on the 3rd READ cycle
    // (2nd for the first cell).
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 16; c++) do_cell(c, (c == 0) ? 2 : 3, c / 4 + 1, c % 4 + 1);
    check("p1_done", int'(bus.done), 1);
    check("p1_done_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("p1_idle_done", int'(bus.done), 0);
    check("p1_idle_busy", int'(bus.busy), 0);
    check("p1_idle_i", int'(bus.i), 1);
    check("p1_idle_j", int'(bus.j), 1);
    check("p1_idle_en_read", int'(bus.en_read), 0);
    check("p1_hold_max", int'(bus.max), -253);
    check("p1_hold_dir", int'(bus.dir), 0);
    @(negedge clk);
    check("p2_restart_busy", int'(bus.busy), 1);
    check("p2_restart_en_read", int'(bus.en_read), 1);
    check("p2_restart_i", int'(bus.i), 1);
    check("p2_restart_j", int'(bus.j), 1);
    bus.start = 1'b0;

    // Second pass with signal on the 1st READ cycle.
    for (int c = 0; c < 16; c++) do_cell(c, 1, c / 4 + 1, c % 4 + 1);
    check("p2_done", int'(bus.done), 1);
    @(negedge clk);
    check("p2_idle_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("p2_no_restart_busy", int'(bus.busy), 0);
    check("p2_no_restart_read", int'(bus.en_read), 0);

    check("done_pulses", done_cnt, 2);
    check("write_pulses", write_cnt, 34);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
